// File: rtl/pipe_skid_buf_pkg.sv
// rtl/pipe_skid_buf_pkg.sv - state encodings and decode helpers for the skid buffer
package pipe_skid_buf_pkg;

  typedef enum logic [1:0] {
    PSB_EMPTY = 2'b00,
    PSB_BUSY  = 2'b01,
    PSB_FULL  = 2'b11
  } psb_state_e;

  function automatic logic psb_holds_word(input logic [1:0] s);
    return s != PSB_EMPTY;
  endfunction

  function automatic logic psb_can_accept(input logic [1:0] s);
    return s != PSB_FULL;
  endfunction

endpackage

// File: rtl/pipe_skid_buf_if.sv
// rtl/pipe_skid_buf_if.sv - upstream/downstream valid/ready handshake bundle
interface pipe_skid_buf_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data
  );
endinterface

// File: rtl/dfflr.sv
// rtl/dfflr.sv - load-enable async active-low reset register, resets to zero
module dfflr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/dffr.sv
// rtl/dffr.sv - async active-low reset register, resets to zero
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry skid buffer; i_ready decoded only from state flops
module pipe_skid_buf
  import pipe_skid_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  pipe_skid_buf_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q;
  logic             main_en, skid_en, main_from_skid;
  logic             in_fire, out_fire;
  psb_state_e       state;

  assign state    = psb_state_e'(state_q);
  assign in_fire  = bus.i_valid & psb_can_accept(state_q);
  assign out_fire = valid_q & bus.o_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    // Flush wins: a handshake completing this cycle is consumed, nothing is stored.
    if (flush) begin
      state_d = PSB_EMPTY;
    end else begin
      case (state)
        PSB_EMPTY: begin
          if (in_fire) begin
            state_d = PSB_BUSY;
            main_en = 1'b1;
          end
        end
        PSB_BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = PSB_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = PSB_EMPTY;
          end
        end
        PSB_FULL: begin
          if (out_fire) begin
            state_d        = PSB_BUSY;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = PSB_EMPTY;
      endcase
    end
  end

  assign main_d  = main_from_skid ? skid_q : bus.i_data;
  assign valid_d = psb_holds_word(state_d);

  dffr #(.W(2)) u_state (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_d),
    .q     (state_q)
  );

  dffr #(.W(1)) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (valid_d),
    .q     (valid_q)
  );

  dfflr #(.W(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  dfflr #(.W(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (bus.i_data),
    .q     (skid_q)
  );

  assign bus.o_valid = valid_q;
  assign bus.i_ready = psb_can_accept(state_q);
  assign bus.o_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// tb/tb_pipe_skid_buf.sv - queue-model scoreboard bench for pipe_skid_buf
module tb_pipe_skid_buf;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  pipe_skid_buf_if #(.WIDTH(W)) bus ();

  pipe_skid_buf #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: held words in order, plus whatever the output register last showed.
  logic [W-1:0] mq[$];
  logic [W-1:0] last_main;
  bit           auto_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit in_x, out_x;
    if (!rst_n) begin
      mq.delete();
      last_main = '0;
    end else begin
      in_x  = bus.i_valid && (mq.size() < 2);
      out_x = (mq.size() > 0) && bus.o_ready;
      if (flush) begin
        if (mq.size() > 0) last_main = mq[0];
        mq.delete();
      end else begin
        if (out_x) last_main = mq.pop_front();
        if (in_x)  mq.push_back(bus.i_data);
      end
    end
  end

  always @(negedge clk) begin
    if (auto_en && rst_n) begin
      chk("model_o_valid", {31'b0, bus.o_valid}, {31'b0, mq.size() > 0});
      chk("model_i_ready", {31'b0, bus.i_ready}, {31'b0, mq.size() < 2});
      chk("model_o_data", bus.o_data, (mq.size() > 0) ? mq[0] : last_main);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    flush       = 1'b0;
    repeat (3) step();
  endtask

  logic [W-1:0] s[4];

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.o_ready = 1'b0;
    s[0] = 32'h11; s[1] = 32'h22; s[2] = 32'h33; s[3] = 32'h44;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("rst_i_ready", {31'b0, bus.i_ready}, 32'd1);
    chk("rst_o_data", bus.o_data, 32'd0);
    step();
    auto_en = 1'b1;

    // Reset asserted while FULL, then first word after release.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data = 32'h1; step();
    bus.i_data  = 32'h2; step();
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("full_i_ready", {31'b0, bus.i_ready}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("async_rst_i_ready", {31'b0, bus.i_ready}, 32'd1);
    chk("async_rst_o_data", bus.o_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.i_valid = 1'b1; bus.i_data = 32'hA5; bus.o_ready = 1'b1;
    @(negedge clk);
    chk("a5_not_yet", {31'b0, bus.o_valid}, 32'd0);
    step();
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("a5_valid", {31'b0, bus.o_valid}, 32'd1);
    chk("a5_data", bus.o_data, 32'hA5);
    drain();

    // Streaming.
    bus.o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1; bus.i_data = s[i];
      @(negedge clk);
      chk("stream_i_ready", {31'b0, bus.i_ready}, 32'd1);
      if (i > 0) chk("stream_data", bus.o_data, s[i-1]);
      step();
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", bus.o_data, 32'h44);
    step();
    @(negedge clk);
    chk("stream_empty", {31'b0, bus.o_valid}, 32'd0);
    drain();

    // Back-pressure.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data = 32'hA; step();
    bus.i_data = 32'hB;
    @(negedge clk);
    chk("bp_ready_busy", {31'b0, bus.i_ready}, 32'd1);
    step();
    bus.i_data = 32'hC;
    @(negedge clk);
    chk("bp_hold_a", bus.o_data, 32'hA);
    chk("bp_ready_full", {31'b0, bus.i_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("bp_still_a", bus.o_data, 32'hA);
    chk("bp_still_full", {31'b0, bus.i_ready}, 32'd0);
    bus.o_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_b", bus.o_data, 32'hB);
    chk("bp_ready_again", {31'b0, bus.i_ready}, 32'd1);
    step();
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("bp_c", bus.o_data, 32'hC);
    step();
    @(negedge clk);
    chk("bp_no_dup", {31'b0, bus.o_valid}, 32'd0);
    drain();

    // Simultaneous in and out while BUSY.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data = 32'h5; step();
    bus.o_ready = 1'b1; bus.i_data = 32'h6; step();
    bus.i_valid = 1'b0; bus.o_ready = 1'b0;
    @(negedge clk);
    chk("sim_data", bus.o_data, 32'h6);
    chk("sim_valid", {31'b0, bus.o_valid}, 32'd1);
    chk("sim_ready", {31'b0, bus.i_ready}, 32'd1);
    drain();

    // Flush while FULL with a word offered.
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data = 32'h1; step();
    bus.i_data = 32'h2; step();
    bus.i_data = 32'h7; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_cur", {31'b0, bus.i_ready}, 32'd0);
    step();
    flush = 1'b0; bus.i_valid = 1'b0;
    @(negedge clk);
    chk("flush_o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("flush_i_ready", {31'b0, bus.i_ready}, 32'd1);
    bus.o_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("flush_no_7_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("flush_main_kept", bus.o_data, 32'h1);
    drain();

    // Random valid/ready/flush against the queue model.
    for (int n = 0; n < 10000; n++) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.o_ready = ($urandom_range(0, 2) != 0);
      bus.i_data  = $urandom;
      flush       = ($urandom_range(0, 63) == 0);
      step();
    end
    drain();

    auto_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
